// File: rtl/instr_load_mem.sv
// rtl/instr_load_mem.sv - instruction memory with byte-stream program loader
`timescale 1ns/1ps
module instr_load_mem #(
    parameter int                ADDR_W = 8,
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] FILL   = '0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load_start,
    input  logic              i_run_start,
    input  logic              i_load_valid,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic              i_load_last,
    output logic              o_load_ready,
    input  logic [ADDR_W-1:0] i_read_address,
    output logic [DATA_W-1:0] o_instruction,
    output logic              o_cpu_reset,
    output logic [ADDR_W:0]   o_load_count,
    output logic              o_overflow,
    output logic              o_busy
);

    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] PTR_ONE   = 1;
    localparam logic [ADDR_W:0]   CNT_ONE   = 1;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_HALT  = 2'd1,
        S_LOAD  = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W:0]     r_load_count;
    logic                r_overflow;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   w_ptr_nxt;
    logic [ADDR_W:0]     w_count_nxt;
    logic                w_ovf_nxt;
    logic                w_we;
    logic [DATA_W-1:0]   w_wdata;

    // One pointer serves as both the clear sweep pointer and the load write pointer.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_count_nxt = r_load_count;
        w_ovf_nxt   = r_overflow;
        w_we        = 1'b0;
        w_wdata     = FILL;
        case (r_state)
            S_CLEAR: begin
                w_we      = 1'b1;
                w_ptr_nxt = r_ptr + PTR_ONE;
                if (r_ptr == LAST_ADDR) begin
                    w_state_nxt = S_HALT;
                end
            end
            S_HALT: begin
                if (i_load_start) begin
                    w_state_nxt = S_LOAD;
                    w_ptr_nxt   = '0;
                    w_count_nxt = '0;
                    w_ovf_nxt   = 1'b0;
                end else if (i_run_start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_LOAD: begin
                if (i_load_valid) begin
                    w_we        = 1'b1;
                    w_wdata     = i_load_data;
                    w_ptr_nxt   = r_ptr + PTR_ONE;
                    w_count_nxt = r_load_count + CNT_ONE;
                    if (i_load_last) begin
                        w_state_nxt = S_HALT;
                    end else if (r_ptr == LAST_ADDR) begin
                        w_ovf_nxt   = 1'b1;
                        w_state_nxt = S_HALT;
                    end
                end
            end
            S_RUN: begin
                if (i_load_start) begin
                    w_state_nxt = S_HALT;
                end
            end
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_CLEAR;
            r_ptr        <= '0;
            r_load_count <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_load_count <= w_count_nxt;
            r_overflow   <= w_ovf_nxt;
        end
    end

    // A reset edge must not commit a partial-program byte.
    always_ff @(posedge i_clk) begin
        if (!i_reset && w_we) begin
            r_mem[r_ptr] <= w_wdata;
        end
    end

    assign o_load_ready  = (r_state == S_LOAD);
    assign o_busy        = (r_state == S_CLEAR) || (r_state == S_LOAD);
    assign o_cpu_reset   = (r_state != S_RUN);
    assign o_load_count  = r_load_count;
    assign o_overflow    = r_overflow;
    assign o_instruction = (r_state == S_RUN) ? r_mem[i_read_address] : FILL;

endmodule

// File: tb/tb_instr_load_mem.sv
// tb/tb_instr_load_mem.sv - self-checking bench for instr_load_mem
`timescale 1ns/1ps
module tb_instr_load_mem;

    localparam int DEPTH = 256;

    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_load_start = 1'b0;
    logic       i_run_start = 1'b0;
    logic       i_load_valid = 1'b0;
    logic [7:0] i_load_data = 8'h00;
    logic       i_load_last = 1'b0;
    logic [7:0] i_read_address = 8'h00;
    logic       o_load_ready;
    logic [7:0] o_instruction;
    logic       o_cpu_reset;
    logic [8:0] o_load_count;
    logic       o_overflow;
    logic       o_busy;

    instr_load_mem #(.ADDR_W(8), .DATA_W(8), .FILL(8'h00)) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_load_start  (i_load_start),
        .i_run_start   (i_run_start),
        .i_load_valid  (i_load_valid),
        .i_load_data   (i_load_data),
        .i_load_last   (i_load_last),
        .o_load_ready  (o_load_ready),
        .i_read_address(i_read_address),
        .o_instruction (o_instruction),
        .o_cpu_reset   (o_cpu_reset),
        .o_load_count  (o_load_count),
        .o_overflow    (o_overflow),
        .o_busy        (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] exp;
    } rd_vec_t;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] model_mem [DEPTH];
    logic [7:0] model_ptr;
    logic [8:0] model_count;
    logic [7:0] exp_q [$];
    rd_vec_t    prog_vecs [6];
    rd_vec_t    empty_vecs [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int k = 0; k < DEPTH; k++) model_mem[k] = 8'h00;
        model_ptr   = 8'h00;
        model_count = 9'd0;
    endtask

    task automatic reset_and_clear();
        int cnt;
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        check("rst_busy", o_busy, 1);
        check("rst_cpu_reset", o_cpu_reset, 1);
        check("rst_load_ready", o_load_ready, 0);
        check("rst_load_count", o_load_count, 0);
        check("rst_overflow", o_overflow, 0);
        check("rst_instruction", o_instruction, 8'h00);
        cnt = 0;
        while (o_busy === 1'b1 && cnt < 1000) begin
            cnt++;
            step();
        end
        check("clear_cycles", cnt, 256);
        check("halt_busy", o_busy, 0);
        check("halt_cpu_reset", o_cpu_reset, 1);
        model_clear();
    endtask

    task automatic go_load(input logic with_run);
        i_load_start = 1'b1;
        i_run_start  = with_run;
        step();
        i_load_start = 1'b0;
        i_run_start  = 1'b0;
        check("load_entry_ready", o_load_ready, 1);
        check("load_entry_cpu_reset", o_cpu_reset, 1);
        check("load_entry_count", o_load_count, 0);
        check("load_entry_overflow", o_overflow, 0);
        model_ptr   = 8'h00;
        model_count = 9'd0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last, input int gap);
        i_load_valid = 1'b1;
        i_load_data  = d;
        i_load_last  = last;
        #1;
        check("ready_before_xfer", o_load_ready, 1);
        step();
        model_mem[model_ptr] = d;
        model_ptr++;
        model_count++;
        i_load_valid = 1'b0;
        i_load_last  = 1'b0;
        for (int g = 0; g < gap; g++) begin
            i_load_data = 8'hEE;
            step();
            check("count_hold_in_gap", o_load_count, model_count);
        end
    endtask

    task automatic go_run();
        i_run_start = 1'b1;
        step();
        i_run_start = 1'b0;
        check("run_cpu_reset", o_cpu_reset, 0);
        check("run_busy", o_busy, 0);
    endtask

    task automatic leave_run();
        i_load_start = 1'b1;
        step();
        i_load_start = 1'b0;
        check("exit_cpu_reset", o_cpu_reset, 1);
        check("exit_instruction_fill", o_instruction, 8'h00);
        check("exit_not_load", o_load_ready, 0);
        check("exit_busy", o_busy, 0);
    endtask

    task automatic read_chk(input logic [7:0] a, input logic [7:0] e, input string name);
        exp_q.push_back(e);
        i_read_address = a;
        #2;
        check(name, o_instruction, exp_q.pop_front());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        prog_vecs[0] = '{8'd0,   8'h41};
        prog_vecs[1] = '{8'd1,   8'h82};
        prog_vecs[2] = '{8'd2,   8'hC3};
        prog_vecs[3] = '{8'd3,   8'h00};
        prog_vecs[4] = '{8'd127, 8'h00};
        prog_vecs[5] = '{8'd255, 8'h00};
        empty_vecs[0] = '{8'd0,   8'h00};
        empty_vecs[1] = '{8'd127, 8'h00};
        empty_vecs[2] = '{8'd255, 8'h00};

        // Power-up clear, then run the blank memory.
        reset_and_clear();
        go_run();
        for (int v = 0; v < 3; v++) read_chk(empty_vecs[v].addr, empty_vecs[v].exp, "empty_read");
        leave_run();

        // Simultaneous load_start/run_start in HALT enters LOAD.
        go_load(1'b1);
        send_byte(8'h41, 1'b0, 0);
        send_byte(8'h82, 1'b0, 0);
        send_byte(8'hC3, 1'b1, 0);
        check("prog_ready_low", o_load_ready, 0);
        check("prog_count", o_load_count, 3);
        check("prog_overflow", o_overflow, 0);
        go_run();
        for (int v = 0; v < 6; v++) read_chk(prog_vecs[v].addr, prog_vecs[v].exp, "prog_read");
        leave_run();

        // Same program with two idle cycles between bytes.
        go_load(1'b0);
        send_byte(8'h41, 1'b0, 2);
        send_byte(8'h82, 1'b0, 2);
        send_byte(8'hC3, 1'b1, 2);
        check("gap_count", o_load_count, 3);
        check("gap_overflow", o_overflow, 0);
        go_run();
        for (int v = 0; v < 6; v++) read_chk(prog_vecs[v].addr, prog_vecs[v].exp, "gap_read");
        leave_run();

        // 257 back-to-back bytes with no load_last: only 256 may land.
        go_load(1'b0);
        for (int i = 0; i < 257; i++) begin
            i_load_valid = 1'b1;
            i_load_data  = i[7:0];
            i_load_last  = 1'b0;
            #1;
            check("ovf_ready", o_load_ready, (i < 256) ? 1 : 0);
            step();
            if (i < 256) begin
                model_mem[model_ptr] = i[7:0];
                model_ptr++;
                model_count++;
            end
        end
        i_load_valid = 1'b0;
        check("ovf_count", o_load_count, 9'h100);
        check("ovf_model_count", o_load_count, model_count);
        check("ovf_flag", o_overflow, 1);
        go_run();
        read_chk(8'd255, 8'hFF, "ovf_read_255");
        read_chk(8'd0,   8'h00, "ovf_read_0");
        read_chk(8'd128, model_mem[128], "ovf_read_128");
        leave_run();
        check("ovf_sticky", o_overflow, 1);

        // Reset after two of three bytes discards the partial program.
        go_load(1'b0);
        send_byte(8'h41, 1'b0, 0);
        send_byte(8'h82, 1'b0, 0);
        reset_and_clear();
        check("midrst_count", o_load_count, 0);
        check("midrst_overflow", o_overflow, 0);
        go_run();
        read_chk(8'd0, model_mem[0], "midrst_read_0");
        read_chk(8'd1, model_mem[1], "midrst_read_1");
        read_chk(8'd0, 8'h00, "midrst_read_0_const");
        read_chk(8'd1, 8'h00, "midrst_read_1_const");
        leave_run();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
